aes_shiftrows_collector: RTL

//  Byte-serial ingress stage directly upstream of mixcolumns in the 8-bit AES datapath.
//  - Accepts one state byte per cycle (column-major: byte k = row k%4, col k/4) from the SubBytes unit.
//  - After 16 bytes, presents the ShiftRows-permuted 128-bit state to mixcolumns over a valid/ready handshake.
//  - Byte 0 maps to m_state[127:120].

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_shiftrows_collector.sv | 134 +++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared types and ShiftRows permutation helpers for the byte-serial AES datapath.
package aes_pkg;

  localparam int AES_NB_BYTES = 16;

  // Element k is state byte k (row k%4, column k/4).
  typedef logic [AES_NB_BYTES-1:0][7:0] aes_state_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    OUT  = 2'd2
  } fill_state_e;

  function automatic aes_state_t aes_shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = s[4*((c+r)%4)+r];
    return o;
  endfunction

  function automatic aes_state_t aes_inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = s[4*((c-r+4)%4)+r];
    return o;
  endfunction

  // Byte 0 lands in the top byte of the bus.
  function automatic logic [127:0] aes_state_to_bus(input aes_state_t s);
    logic [127:0] b;
    for (int k = 0; k < AES_NB_BYTES; k++)
      b[127-8*k -: 8] = s[k];
    return b;
  endfunction

endpackage

// File: rtl/aes_shiftrows_collector.sv
// Collects 16 SubBytes output bytes and hands the ShiftRows-permuted state to mixcolumns.
// Define AES_INV_SHIFTROWS_EN to honour the per-block inv input (InvShiftRows).
module aes_shiftrows_collector
  import aes_pkg::*;
#(
  parameter int DOUBLE_BUF = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  input  logic         inv,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_state,
  output logic         err
);

  fill_state_e  state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  aes_state_t   fill_q, fill_d;
  logic [127:0] m_state_q, m_state_d;
  logic         m_valid_q, m_valid_d;
  logic         err_q, err_d;

  logic         s_ready_c;
  logic         accept, last_pos, frame_bad, blk_done, slot_free, m_xfer;
  aes_state_t   fill_nxt, perm_src, perm_out;

  assign s_ready_c = (DOUBLE_BUF != 0) ? (state_q == FILL) : (!m_valid_q && !clear);
  assign accept    = s_valid && s_ready_c;
  assign last_pos  = (cnt_q == 4'd15);
  assign frame_bad = accept && (s_last != last_pos);
  assign blk_done  = accept && last_pos && s_last;
  assign m_xfer    = m_valid_q && m_ready;
  assign slot_free = !m_valid_q || m_ready;

  always_comb begin
    fill_nxt = fill_q;
    if (accept) fill_nxt[cnt_q] = s_data;
  end

  // A held block permutes from the stored fill; otherwise the 16th byte is folded in on the fly.
  assign perm_src = (state_q == HOLD) ? fill_q : fill_nxt;

`ifdef AES_INV_SHIFTROWS_EN
  logic inv_q, inv_d;
  assign inv_d = (accept && cnt_q == 4'd0) ? inv : inv_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
  assign perm_out = inv_q ? aes_inv_shift_rows(perm_src) : aes_shift_rows(perm_src);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign perm_out   = aes_shift_rows(perm_src);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    m_state_d = m_state_q;
    m_valid_d = m_valid_q;
    err_d     = 1'b0;
    if (m_xfer) m_valid_d = 1'b0;
    if (clear) begin
      cnt_d     = 4'd0;
      m_valid_d = 1'b0;
      state_d   = FILL;
    end else begin
      case (state_q)
        HOLD: begin
          if (m_ready) begin
            m_state_d = aes_state_to_bus(perm_out);
            m_valid_d = 1'b1;
            state_d   = FILL;
          end
        end
        OUT: begin
          if (m_xfer) state_d = FILL;
        end
        default: begin
          if (accept) begin
            fill_d = fill_nxt;
            if (frame_bad) begin
              err_d = 1'b1;
              cnt_d = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
            if (blk_done) begin
              if (slot_free) begin
                m_state_d = aes_state_to_bus(perm_out);
                m_valid_d = 1'b1;
                state_d   = (DOUBLE_BUF != 0) ? FILL : OUT;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= 4'd0;
      fill_q    <= '0;
      m_state_q <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      m_state_q <= m_state_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

  assign s_ready = s_ready_c;
  assign m_valid = m_valid_q;
  assign m_state = m_state_q;
  assign err     = err_q;

endmodule
